// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// No logic, so no latency or backpressure of its own.
package regfile_pkg;

    localparam int DW_DEF = 64;
    localparam int AW_DEF = 5;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant logic with a last-winner pointer: round-robin or fixed (requester 1 wins).
// Grants are combinational from the requests; Reset or Hold forces both grants low.
module rr_arbiter2
    import regfile_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hold_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    req_id_e last_q, last_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        last_d = last_q;
        if (!rst_i && !hold_i) begin
            if (req0_i && req1_i) begin
                // On a tie the requester that did not win last time goes next.
                if (PRIO_MODE == PRIO_FIXED || last_q == REQ_ALU) begin
                    gnt1_o = 1'b1;
                end else begin
                    gnt0_o = 1'b1;
                end
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
        if (gnt0_o) begin
            last_d = REQ_ALU;
        end else if (gnt1_o) begin
            last_d = REQ_MEM;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= REQ_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the register file's single write port.
// Winner is staged one cycle (valid edge N..N+1); losers wait with Valid held, Hold stalls both.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Hold,
    input  logic          AluValid,
    input  logic [AW-1:0] AluRW,
    input  logic [DW-1:0] AluData,
    output logic          AluReady,
    input  logic          MemValid,
    input  logic [AW-1:0] MemRW,
    input  logic [DW-1:0] MemData,
    output logic          MemReady,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] BusW,
    output logic          RegWr,
    input  logic [AW-1:0] RA,
    input  logic [AW-1:0] RB,
    output logic          FwdA,
    output logic          FwdB
);

    localparam logic [AW-1:0] XZR_A = AW'(XZR);

    logic          alu_gnt, mem_gnt;
    logic          regwr_q, regwr_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] busw_q, busw_d;

    rr_arbiter2 #(
        .PRIO_MODE(PRIO_MODE)
    ) u_arb (
        .clk_i (Clk),
        .rst_i (Reset),
        .hold_i(Hold),
        .req0_i(AluValid),
        .req1_i(MemValid),
        .gnt0_o(alu_gnt),
        .gnt1_o(mem_gnt)
    );

    assign AluReady = alu_gnt;
    assign MemReady = mem_gnt;

    always_comb begin
        regwr_d = 1'b0;
        rw_d    = rw_q;
        busw_d  = busw_q;
        // Writes to XZR are consumed but never reach the register file.
        if (mem_gnt) begin
            rw_d    = MemRW;
            busw_d  = MemData;
            regwr_d = (MemRW != XZR_A);
        end else if (alu_gnt) begin
            rw_d    = AluRW;
            busw_d  = AluData;
            regwr_d = (AluRW != XZR_A);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            regwr_q <= 1'b0;
            rw_q    <= XZR_A;
            busw_q  <= '0;
        end else begin
            regwr_q <= regwr_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
        end
    end

    assign RegWr = regwr_q;
    assign RW    = rw_q;
    assign BusW  = busw_q;

    assign FwdA = regwr_q && (RA == rw_q) && (RA != XZR_A);
    assign FwdB = regwr_q && (RB == rw_q) && (RB != XZR_A);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: round-robin and fixed-priority instances share stimulus.
// Directed steps then random traffic, checked against a grant/regfile model.
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset, Hold;
    logic        AluValid, MemValid;
    logic [4:0]  AluRW, MemRW, RA, RB;
    logic [63:0] AluData, MemData;

    logic        a_rdy [2];
    logic        m_rdy [2];
    logic        regwr [2];
    logic [4:0]  rw    [2];
    logic [63:0] busw  [2];
    logic        fwda  [2];
    logic        fwdb  [2];

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] rf     [2][32] = '{default: 64'd0};
    logic [63:0] ref_rf [2][32] = '{default: 64'd0};

    bit          m_regwr [2];
    logic [4:0]  m_rw    [2];
    logic [63:0] m_busw  [2];
    int          m_last  [2];
    int          won     [2] = '{-1, -1};

    always #5 Clk = ~Clk;

    regfile_wb_arbiter #(.DW(64), .AW(5), .PRIO_MODE(0)) u_rr (
        .Clk(Clk), .Reset(Reset), .Hold(Hold),
        .AluValid(AluValid), .AluRW(AluRW), .AluData(AluData), .AluReady(a_rdy[0]),
        .MemValid(MemValid), .MemRW(MemRW), .MemData(MemData), .MemReady(m_rdy[0]),
        .RW(rw[0]), .BusW(busw[0]), .RegWr(regwr[0]),
        .RA(RA), .RB(RB), .FwdA(fwda[0]), .FwdB(fwdb[0])
    );

    regfile_wb_arbiter #(.DW(64), .AW(5), .PRIO_MODE(1)) u_fx (
        .Clk(Clk), .Reset(Reset), .Hold(Hold),
        .AluValid(AluValid), .AluRW(AluRW), .AluData(AluData), .AluReady(a_rdy[1]),
        .MemValid(MemValid), .MemRW(MemRW), .MemData(MemData), .MemReady(m_rdy[1]),
        .RW(rw[1]), .BusW(busw[1]), .RegWr(regwr[1]),
        .RA(RA), .RB(RB), .FwdA(fwda[1]), .FwdB(fwdb[1])
    );

    // Register file behaviour: commit at the falling edge inside the staged cycle.
    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            if (regwr[d]) rf[d][rw[d]] <= busw[d];
        end
    end

    function automatic logic [63:0] rd(input int d, input int idx);
        return (idx == 31) ? 64'd0 : rf[d][idx];
    endfunction

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    // Who the rules say wins this cycle: -1 none, 0 ALU, 1 MEM.
    function automatic int winner(input bit fixed, input int last, input logic rst,
                                  input logic hold, input logic v0, input logic v1);
        if (rst || hold) return -1;
        if (v0 && v1) return fixed ? 1 : 1 - last;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic cycle();
        int w [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            w[d] = winner(d == 1, m_last[d], Reset, Hold, AluValid, MemValid);
            chk("AluReady", d, 64'(a_rdy[d]), 64'(w[d] == 0));
            chk("MemReady", d, 64'(m_rdy[d]), 64'(w[d] == 1));
        end
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            if (Reset) begin
                m_regwr[d] = 1'b0;
                m_rw[d]    = 5'd31;
                m_busw[d]  = 64'd0;
                m_last[d]  = 1;
            end else if (w[d] >= 0) begin
                m_rw[d]    = (w[d] == 1) ? MemRW : AluRW;
                m_busw[d]  = (w[d] == 1) ? MemData : AluData;
                m_regwr[d] = (m_rw[d] != 5'd31);
                m_last[d]  = w[d];
            end else begin
                m_regwr[d] = 1'b0;
            end
            if (m_regwr[d]) ref_rf[d][m_rw[d]] = m_busw[d];
            won[d] = Reset ? -1 : w[d];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("RegWr", d, 64'(regwr[d]), 64'(m_regwr[d]));
            chk("RW", d, 64'(rw[d]), 64'(m_rw[d]));
            chk("BusW", d, busw[d], m_busw[d]);
            chk("FwdA", d, 64'(fwda[d]), 64'(m_regwr[d] && RA == m_rw[d] && RA != 5'd31));
            chk("FwdB", d, 64'(fwdb[d]), 64'(m_regwr[d] && RB == m_rw[d] && RB != 5'd31));
        end
        @(negedge Clk);
        #1;
    endtask

    initial begin
        int ka, km;
        Reset = 1'b1; Hold = 1'b0;
        AluValid = 1'b1; AluRW = 5'd1; AluData = 64'h1111;
        MemValid = 1'b1; MemRW = 5'd2; MemData = 64'h2222;
        RA = 5'd0; RB = 5'd0;

        // Reset with both requesters pending.
        cycle();
        cycle();
        chk("rst_regwr", 0, 64'(regwr[0]), 64'd0);
        chk("rst_rw", 0, 64'(rw[0]), 64'd31);
        chk("rst_busw", 0, busw[0], 64'd0);
        chk("rst_fwda", 0, 64'(fwda[0]), 64'd0);
        Reset = 1'b0;
        #1;
        chk("first_tie_alu", 0, 64'(a_rdy[0]), 64'd1);

        // Six cycles of contention.
        ka = 0; km = 0;
        AluRW = 5'd10; MemRW = 5'd20;
        AluData = 64'hA000; MemData = 64'hB000;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_alu_seq", 0, 64'(a_rdy[0]), 64'(i % 2 == 0));
            chk("fx_mem", 1, 64'(m_rdy[1]), 64'd1);
            chk("fx_alu", 1, 64'(a_rdy[1]), 64'd0);
            cycle();
            chk("rr_regwr", 0, 64'(regwr[0]), 64'd1);
            if (won[0] == 0) begin
                ka++; AluRW = 5'(10 + ka); AluData = 64'hA000 + 64'(ka);
            end else if (won[0] == 1) begin
                km++; MemRW = 5'(20 + km); MemData = 64'hB000 + 64'(km);
            end
        end

        // Hold freezes grants and the pointer.
        Hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("hold_regwr", 0, 64'(regwr[0]), 64'd0);
        end
        Hold = 1'b0;
        #1;
        chk("hold_resume_alu", 0, 64'(a_rdy[0]), 64'd1);
        cycle();
        AluValid = 1'b0; MemValid = 1'b0;
        cycle();

        // Single ALU write with bypass on RA.
        AluValid = 1'b1; AluRW = 5'd5; AluData = 64'hDEAD_BEEF; RA = 5'd5; RB = 5'd6;
        cycle();
        AluValid = 1'b0;
        chk("single_regwr", 0, 64'(regwr[0]), 64'd1);
        chk("single_rw", 0, 64'(rw[0]), 64'd5);
        chk("single_busw", 0, busw[0], 64'hDEAD_BEEF);
        chk("single_fwda", 0, 64'(fwda[0]), 64'd1);
        chk("single_rf", 0, rd(0, 5), 64'hDEAD_BEEF);

        // Write to XZR is consumed without a register write.
        MemValid = 1'b1; MemRW = 5'd31; MemData = 64'd7; RA = 5'd31;
        #1;
        chk("xzr_ready", 0, 64'(m_rdy[0]), 64'd1);
        cycle();
        MemValid = 1'b0;
        chk("xzr_regwr", 0, 64'(regwr[0]), 64'd0);
        chk("xzr_fwda", 0, 64'(fwda[0]), 64'd0);
        chk("xzr_rf", 0, rd(0, 31), 64'd0);

        // Reset beats a pending transfer to register 3.
        AluValid = 1'b1; AluRW = 5'd3; AluData = 64'h3333; Reset = 1'b1;
        cycle();
        chk("rst_kill_regwr", 0, 64'(regwr[0]), 64'd0);
        Reset = 1'b0; AluValid = 1'b0;
        cycle();
        chk("rst_kill_rf", 0, rd(0, 3), 64'd0);

        // Staged write followed by reset: stage is cleared.
        AluValid = 1'b1; AluRW = 5'd7; AluData = 64'h7777;
        cycle();
        AluValid = 1'b0; Reset = 1'b1;
        cycle();
        chk("rst_drop_regwr", 0, 64'(regwr[0]), 64'd0);
        Reset = 1'b0;

        // Random traffic; requesters keep Valid/RW/Data until dut0 accepts.
        won = '{-1, -1};
        for (int i = 0; i < 400; i++) begin
            if (!AluValid || won[0] == 0) begin
                AluValid = ($urandom_range(0, 3) != 0);
                AluRW    = 5'($urandom_range(0, 31));
                AluData  = {$urandom, $urandom};
            end
            if (!MemValid || won[0] == 1) begin
                MemValid = ($urandom_range(0, 3) != 0);
                MemRW    = 5'($urandom_range(0, 31));
                MemData  = {$urandom, $urandom};
            end
            Hold  = ($urandom_range(0, 9) == 0);
            Reset = ($urandom_range(0, 29) == 0);
            RA    = 5'($urandom_range(0, 31));
            RB    = 5'($urandom_range(0, 31));
            cycle();
        end
        Reset = 1'b0; Hold = 1'b0; AluValid = 1'b0; MemValid = 1'b0;
        cycle();

        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) begin
                chk("rf_final", d, rd(d, r), (r == 31) ? 64'd0 : ref_rf[d][r]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
